// File: rtl/skip_pkg.sv
// Shared constants and types for the skip ring and its clock prescaler.
package skip_pkg;
   localparam int unsigned SKIP_W        = 32;
   localparam logic [31:0] SKIP_DEF_HALF = 32'h0100_0000;
   typedef logic [SKIP_W-1:0] half_t;
endpackage

// File: rtl/skip_prescaler_if.sv
// Divisor load handshake between a controller (master) and the prescaler (slave).
interface skip_prescaler_if #(parameter int unsigned W = 32);
   logic         LD_VALID;
   logic [W-1:0] LD_HALF;
   logic         LD_READY;

   modport master (output LD_VALID, LD_HALF, input  LD_READY);
   modport slave  (input  LD_VALID, LD_HALF, output LD_READY);
endinterface

// File: rtl/prescale_load_slot.sv
// One-entry holding register for a pending half-period; empties on apply or flush.
module prescale_load_slot #(
   parameter int unsigned W = 32
) (
   input  logic         mCLK,
   input  logic         nRST,
   input  logic         accept,
   input  logic         apply,
   input  logic         flush,
   input  logic [W-1:0] din,
   output logic         full,
   output logic [W-1:0] dout
);
   // accept only fires while empty, so it never collides with apply
   always_ff @(posedge mCLK or negedge nRST) begin
      if (!nRST) begin
         full <= 1'b0;
         dout <= '0;
      end else if (accept) begin
         full <= 1'b1;
         dout <= din;
      end else if (apply || flush) begin
         full <= 1'b0;
      end
   end
endmodule

// File: rtl/skip_prescaler.sv
// Loadable-half-period clock prescaler for the skip ring; divisor swaps only at period end.
// Optional PRESCALE_SYNC_EN adds a SYNC input that re-phases the output and applies a pending load.
module skip_prescaler
   import skip_pkg::*;
#(
   parameter int unsigned  W        = SKIP_W,
   parameter logic [W-1:0] DEF_HALF = W'(SKIP_DEF_HALF)
) (
   input  logic             mCLK,
   input  logic             nRST,
   input  logic             E,
`ifdef PRESCALE_SYNC_EN
   input  logic             SYNC,
`endif
   skip_prescaler_if.slave  ld,
   output logic [W-1:0]     CUR_HALF,
   output logic             oCLK,
   output logic             oTICK
);
   logic [W-1:0] cnt;
   logic [W-1:0] h_eff;
   logic [W-1:0] slot_q;
   logic         slot_full;
   logic         accept;
   logic         wrap;
   logic         apply_pt;
   logic         sync;

`ifdef PRESCALE_SYNC_EN
   assign sync = SYNC;
`else
   assign sync = 1'b0;
`endif

   // a zero half-period behaves as one so the counter always wraps
   assign h_eff    = (CUR_HALF == '0) ? W'(1) : CUR_HALF;
   assign wrap     = (cnt == h_eff - W'(1));
   assign apply_pt = E && wrap && oCLK && slot_full && !sync;
   assign accept   = ld.LD_VALID && !slot_full;
   assign ld.LD_READY = !slot_full;

   prescale_load_slot #(.W(W)) u_slot (
      .mCLK   (mCLK),
      .nRST   (nRST),
      .accept (accept),
      .apply  (apply_pt),
      .flush  (sync),
      .din    (ld.LD_HALF),
      .full   (slot_full),
      .dout   (slot_q)
   );

   always_ff @(posedge mCLK or negedge nRST) begin
      if (!nRST) begin
         cnt      <= '0;
         oCLK     <= 1'b0;
         oTICK    <= 1'b0;
         CUR_HALF <= DEF_HALF;
      end else if (sync) begin
         cnt   <= '0;
         oCLK  <= 1'b0;
         oTICK <= 1'b0;
         if (slot_full) CUR_HALF <= slot_q;
      end else begin
         oTICK <= 1'b0;
         if (E) begin
            if (wrap) begin
               cnt   <= '0;
               oCLK  <= ~oCLK;
               oTICK <= ~oCLK;
               if (apply_pt) CUR_HALF <= slot_q;
            end else begin
               cnt <= cnt + W'(1);
            end
         end
      end
   end
endmodule
